aes_ahb_feeder: RTL

AHB-Lite master that sits directly upstream of the AES AHB slave and feeds it 128-bit plaintext/key blocks. Blocks arrive on a valid/ready stream and are buffered in a 2-entry FIFO. Each block is issued as one single, non-sequential, 128-bit AHB write to a fixed target address. Error responses are retried a bounded number of times, and completion or failure is reported with one-cycle pulses.

---
 rtl/aes_ahb_feeder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/aes_ahb_feeder.sv
// aes_ahb_feeder: AHB-Lite master that drains a 2-entry block FIFO into the
// AES slave as single 128-bit NONSEQ writes. ERROR responses are retried up
// to MAX_RETRY times. Each block ends with a done_pulse or an err_pulse.
module aes_ahb_feeder #(
    parameter logic [31:0] TARGET_ADDR = 32'hF0F0F0F0,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic [31:0]  HADDR,
    output logic [2:0]   HBURST,
    output logic         HMASTLOCK,
    output logic [3:0]   HPORT,
    output logic [2:0]   HSIZE,
    output logic [1:0]   HTRANS,
    output logic [127:0] HWDATA,
    output logic         HWRITE,
    output logic         HSELx,
    input  logic         HREADY,
    input  logic         HRESP,
    output logic         done_pulse,
    output logic         err_pulse,
    output logic         busy
);

    localparam logic [2:0] MAX_RETRY_C   = 3'(MAX_RETRY);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

    state_t       state;
    logic [2:0]   retry_cnt;
    logic [127:0] fifo_mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    logic push;
    logic pop;
    logic data_ok;
    logic data_err;
    logic retry_left;
    logic addr_next;

    assign in_ready   = (count != 2'd2);
    assign push       = in_valid && in_ready;
    assign data_ok    = (state == ST_DATA) && HREADY && !HRESP;
    assign data_err   = (state == ST_DATA) && HREADY && HRESP;
    assign retry_left = (retry_cnt < MAX_RETRY_C);
    assign pop        = data_ok || (data_err && !retry_left);
    assign busy       = (state != ST_IDLE) || (count != 2'd0);

    // The next cycle is an address phase: new issue, wait-state hold, or re-issue after ERR.
    assign addr_next  = ((state == ST_IDLE) && (count != 2'd0)) ||
                        ((state == ST_ADDR) && !HREADY) ||
                        (state == ST_ERR);

    // SINGLE bursts only and no locked transfers.
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    // Block storage write port.
    // NOTE: the data array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Transfer FSM with registered bus outputs and completion pulses.
    // NOTE: sequential state uses non-blocking assignments only, so every branch sees the values from before the edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            retry_cnt  <= 3'd0;
            HADDR      <= 32'd0;
            HPORT      <= 4'd0;
            HSIZE      <= 3'd0;
            HTRANS     <= HTRANS_IDLE;
            HWRITE     <= 1'b0;
            HSELx      <= 1'b0;
            HWDATA     <= 128'd0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            HADDR      <= addr_next ? TARGET_ADDR : 32'd0;
            HPORT      <= addr_next ? 4'b0001 : 4'd0;
            HSIZE      <= addr_next ? 3'b100 : 3'd0;
            HTRANS     <= addr_next ? HTRANS_NONSEQ : HTRANS_IDLE;
            HWRITE     <= addr_next;
            HSELx      <= addr_next;
            HWDATA     <= 128'd0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (count != 2'd0) state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state  <= ST_DATA;
                        HWDATA <= fifo_mem[rd_ptr];
                    end
                end
                ST_DATA: begin
                    if (!HREADY) begin
                        HWDATA <= HWDATA;
                    end else if (!HRESP) begin
                        done_pulse <= 1'b1;
                        retry_cnt  <= 3'd0;
                        state      <= ST_IDLE;
                    end else if (retry_left) begin
                        retry_cnt  <= retry_cnt + 3'd1;
                        state      <= ST_ERR;
                    end else begin
                        err_pulse  <= 1'b1;
                        retry_cnt  <= 3'd0;
                        state      <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state <= ST_ADDR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
